// File: rtl/tb_fromhost_driver_pkg.sv
// Shared encodings for the fromhost mailbox driver: response status codes and FSM states.
package tb_defines;

   typedef enum logic [1:0] {
      FH_OK      = 2'b00,
      FH_TIMEOUT = 2'b01,
      FH_BADCMD  = 2'b10
   } fh_status_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_RESP     = 2'd3
   } fh_state_t;

endpackage

// File: rtl/tb_fromhost_driver_if.sv
// Command, fromhost register and response signals between the host side and the driver.
interface tb_fromhost_driver_if #(
   parameter int DW = 32,
   parameter int CW = 32
);
   logic          cmd_valid;
   logic [DW-1:0] cmd_data;
   logic          cmd_ready;
   logic          fromhost_we;
   logic [DW-1:0] fromhost_wdata;
   logic [DW-1:0] fromhost_rdata;
   logic          resp_valid;
   logic [1:0]    resp_status;
   logic [CW-1:0] resp_latency;
   logic [CW-1:0] cmd_sent_cnt;
   logic          busy;

   // Host / bench side: offers commands and models the core register read-back.
   modport master (
      output cmd_valid, cmd_data, fromhost_rdata,
      input  cmd_ready, fromhost_we, fromhost_wdata,
      input  resp_valid, resp_status, resp_latency, cmd_sent_cnt, busy
   );

   // Driver side.
   modport slave (
      input  cmd_valid, cmd_data, fromhost_rdata,
      output cmd_ready, fromhost_we, fromhost_wdata,
      output resp_valid, resp_status, resp_latency, cmd_sent_cnt, busy
   );
endinterface

// File: rtl/tb_fromhost_driver_sat.sv
// Up-counter with synchronous clear; optionally saturates at all-ones instead of wrapping.
module tb_sat_counter #(
   parameter int CW       = 32,
   parameter bit SATURATE = 1'b1
) (
   input  logic          tb_clk,
   input  logic          tb_rst,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] count
);
   logic [CW-1:0] count_reg;

   always_ff @(posedge tb_clk or posedge tb_rst) begin
      if (tb_rst) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && !(SATURATE && (&count_reg))) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;
endmodule

// File: rtl/tb_fromhost_driver.sv
// Writes host commands into the core fromhost register and waits for the program to clear it.
module tb_fromhost_driver
   import tb_defines::*;
#(
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int CW             = 32
) (
   input logic                 tb_clk,
   input logic                 tb_rst,
   tb_fromhost_driver_if.slave fh
);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAT  = CW'(TIMEOUT_CYCLES);

   fh_state_t     state_reg, state_next;
   logic          armed_reg, armed_next;
   logic          we_reg, we_next;
   logic [DW-1:0] wdata_reg, wdata_next;
   logic          resp_valid_reg, resp_valid_next;
   logic [1:0]    status_reg, status_next;
   logic [CW-1:0] latency_reg, latency_next;

   logic          ack;
   logic          timeout_hit;
   logic [CW-1:0] lat_count;

   // Index 0: latency/timeout counter (saturating); index 1: sent-command counter (wrapping).
   logic [1:0]          cnt_clear;
   logic [1:0]          cnt_enable;
   logic [1:0][CW-1:0]  cnt_value;

   assign cnt_clear  = {1'b0, state_reg == ST_WRITE};
   assign cnt_enable = {state_reg == ST_WRITE, state_reg == ST_WAIT_ACK};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         tb_sat_counter #(
            .CW       (CW),
            .SATURATE (gi == 0)
         ) u_cnt (
            .tb_clk (tb_clk),
            .tb_rst (tb_rst),
            .clear  (cnt_clear[gi]),
            .enable (cnt_enable[gi]),
            .count  (cnt_value[gi])
         );
      end
   endgenerate

   assign lat_count = cnt_value[0];

   // A zero read-back only counts once the written value has been seen at least once.
   assign ack         = armed_reg && (fh.fromhost_rdata == '0);
   assign timeout_hit = (lat_count == TIMEOUT_LAST);

   always_ff @(posedge tb_clk or posedge tb_rst) begin
      if (tb_rst) begin
         state_reg      <= ST_IDLE;
         armed_reg      <= 1'b0;
         we_reg         <= 1'b0;
         wdata_reg      <= '0;
         resp_valid_reg <= 1'b0;
         status_reg     <= 2'b00;
         latency_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         armed_reg      <= armed_next;
         we_reg         <= we_next;
         wdata_reg      <= wdata_next;
         resp_valid_reg <= resp_valid_next;
         status_reg     <= status_next;
         latency_reg    <= latency_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      armed_next      = armed_reg;
      we_next         = 1'b0;
      wdata_next      = wdata_reg;
      resp_valid_next = 1'b0;
      status_next     = status_reg;
      latency_next    = latency_reg;
      case (state_reg)
         ST_IDLE: begin
            if (fh.cmd_valid) begin
               if (fh.cmd_data != '0) begin
                  state_next = ST_WRITE;
                  we_next    = 1'b1;
                  wdata_next = fh.cmd_data;
               end else begin
                  state_next      = ST_RESP;
                  resp_valid_next = 1'b1;
                  status_next     = FH_BADCMD;
                  latency_next    = '0;
               end
            end
         end
         ST_WRITE: begin
            state_next = ST_WAIT_ACK;
            armed_next = 1'b0;
         end
         ST_WAIT_ACK: begin
            if (fh.fromhost_rdata == wdata_reg) begin
               armed_next = 1'b1;
            end
            // Acknowledge takes priority over a timeout landing on the same cycle.
            if (ack) begin
               state_next      = ST_RESP;
               resp_valid_next = 1'b1;
               status_next     = FH_OK;
               latency_next    = lat_count + 1'b1;
            end else if (timeout_hit) begin
               state_next      = ST_RESP;
               resp_valid_next = 1'b1;
               status_next     = FH_TIMEOUT;
               latency_next    = TIMEOUT_LAT;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign fh.cmd_ready      = (state_reg == ST_IDLE);
   assign fh.busy           = (state_reg != ST_IDLE);
   assign fh.fromhost_we    = we_reg;
   assign fh.fromhost_wdata = wdata_reg;
   assign fh.resp_valid     = resp_valid_reg;
   assign fh.resp_status    = status_reg;
   assign fh.resp_latency   = latency_reg;
   assign fh.cmd_sent_cnt   = cnt_value[1];
endmodule

// File: tb/tb_tb_fromhost_driver.sv
// Directed bench for the fromhost driver: unit 0 uses a 16-cycle timeout, unit 1 an 8-cycle one.
`timescale 1ns/1ps
module tb_tb_fromhost_driver;
   localparam logic [1:0] ST_OK = 2'b00;
   localparam logic [1:0] ST_TO = 2'b01;
   localparam logic [1:0] ST_BAD = 2'b10;

   logic tb_clk = 1'b0;
   logic tb_rst = 1'b1;
   always #5 tb_clk = ~tb_clk;

   logic [1:0]        drv_cmd_valid;
   logic [1:0][31:0]  drv_cmd_data;
   logic [1:0][31:0]  drv_rdata;

   logic [1:0]        dut_cmd_ready;
   logic [1:0]        dut_we;
   logic [1:0][31:0]  dut_wdata;
   logic [1:0]        dut_resp_valid;
   logic [1:0][1:0]   dut_status;
   logic [1:0][31:0]  dut_latency;
   logic [1:0][31:0]  dut_sent;
   logic [1:0]        dut_busy;

   int tests_run = 0;
   int tests_failed = 0;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         tb_fromhost_driver_if #(.DW(32), .CW(32)) fh_if ();

         assign fh_if.cmd_valid      = drv_cmd_valid[gi];
         assign fh_if.cmd_data       = drv_cmd_data[gi];
         assign fh_if.fromhost_rdata = drv_rdata[gi];
         assign dut_cmd_ready[gi]    = fh_if.cmd_ready;
         assign dut_we[gi]           = fh_if.fromhost_we;
         assign dut_wdata[gi]        = fh_if.fromhost_wdata;
         assign dut_resp_valid[gi]   = fh_if.resp_valid;
         assign dut_status[gi]       = fh_if.resp_status;
         assign dut_latency[gi]      = fh_if.resp_latency;
         assign dut_sent[gi]         = fh_if.cmd_sent_cnt;
         assign dut_busy[gi]         = fh_if.busy;

         tb_fromhost_driver #(
            .DW             (32),
            .TIMEOUT_CYCLES ((gi == 0) ? 16 : 8),
            .CW             (32)
         ) u_dut (
            .tb_clk (tb_clk),
            .tb_rst (tb_rst),
            .fh     (fh_if.slave)
         );
      end
   endgenerate

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic check_idle_reset(input int u, input string tag);
      check_eq({tag, "_ready"},   64'(dut_cmd_ready[u]),  64'd1);
      check_eq({tag, "_busy"},    64'(dut_busy[u]),       64'd0);
      check_eq({tag, "_we"},      64'(dut_we[u]),         64'd0);
      check_eq({tag, "_wdata"},   64'(dut_wdata[u]),      64'd0);
      check_eq({tag, "_rvalid"},  64'(dut_resp_valid[u]), 64'd0);
      check_eq({tag, "_status"},  64'(dut_status[u]),     64'd0);
      check_eq({tag, "_latency"}, 64'(dut_latency[u]),    64'd0);
      check_eq({tag, "_sent"},    64'(dut_sent[u]),       64'd0);
   endtask

   // Core model: in WAIT cycle k the register reads 0 before arm_k, the command from arm_k on,
   // and 0 again on clr_k (clr_k = 0 means the program never clears it).
   task automatic do_cmd(input int u, input string name, input logic [31:0] data,
                         input int arm_k, input int clr_k, input logic [1:0] exp_st,
                         input logic [31:0] exp_lat, input int exp_k, input logic [31:0] exp_sent);
      int k;
      int extra_we;
      check_eq({name, "_ready"}, 64'(dut_cmd_ready[u]), 64'd1);
      drv_cmd_valid[u] = 1'b1;
      drv_cmd_data[u]  = data;
      tick();
      drv_cmd_valid[u] = 1'b0;
      drv_cmd_data[u]  = 32'hA5A5_0F0F;
      if (data != 32'd0) begin
         check_eq({name, "_we"},    64'(dut_we[u]),    64'd1);
         check_eq({name, "_wdata"}, 64'(dut_wdata[u]), 64'(data));
         tick();
      end else begin
         check_eq({name, "_no_we"}, 64'(dut_we[u]), 64'd0);
      end
      k = 0;
      extra_we = 0;
      while (!dut_resp_valid[u] && k < 100) begin
         k++;
         drv_rdata[u] = (k == clr_k) ? 32'd0 : ((k >= arm_k) ? data : 32'd0);
         if (dut_we[u]) extra_we++;
         tick();
      end
      check_eq({name, "_resp_cycle"}, 64'(k),                 64'(exp_k));
      check_eq({name, "_extra_we"},   64'(extra_we),          64'd0);
      check_eq({name, "_rvalid"},     64'(dut_resp_valid[u]), 64'd1);
      check_eq({name, "_status"},     64'(dut_status[u]),     64'(exp_st));
      check_eq({name, "_latency"},    64'(dut_latency[u]),    64'(exp_lat));
      check_eq({name, "_sent"},       64'(dut_sent[u]),       64'(exp_sent));
      $display("[TB] %s: unit %0d cmd 0x%08h status %0d latency %0d sent %0d after %0d wait cycles",
               name, u, data, dut_status[u], dut_latency[u], dut_sent[u], k);
      drv_rdata[u] = 32'd0;
      tick();
      check_eq({name, "_rvalid_drop"}, 64'(dut_resp_valid[u]), 64'd0);
      check_eq({name, "_ready_after"}, 64'(dut_cmd_ready[u]),  64'd1);
      check_eq({name, "_busy_after"},  64'(dut_busy[u]),       64'd0);
      check_eq({name, "_status_hold"}, 64'(dut_status[u]),     64'(exp_st));
      check_eq({name, "_lat_hold"},    64'(dut_latency[u]),    64'(exp_lat));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      drv_cmd_valid = '0;
      drv_cmd_data  = '0;
      drv_rdata     = '0;
      tb_rst        = 1'b1;
      repeat (3) @(posedge tb_clk);
      #1;
      check_idle_reset(0, "reset_u0");
      check_idle_reset(1, "reset_u1");
      tb_rst = 1'b0;
      tick();

      do_cmd(0, "basic_ok",  32'h0000_0005, 3, 10, ST_OK,  32'd10, 10, 32'd1);
      do_cmd(0, "timeout",   32'h0000_00AB, 1, 0,  ST_TO,  32'd16, 16, 32'd2);
      do_cmd(0, "badcmd",    32'h0000_0000, 1, 0,  ST_BAD, 32'd0,  0,  32'd2);
      do_cmd(0, "early_zero",32'h0000_0007, 3, 4,  ST_OK,  32'd4,  4,  32'd3);
      do_cmd(1, "tie",       32'h0000_0009, 1, 8,  ST_OK,  32'd8,  8,  32'd1);

      // Reset while waiting for an armed acknowledge: the pending command must vanish.
      drv_cmd_valid[0] = 1'b1;
      drv_cmd_data[0]  = 32'h0000_0011;
      tick();
      drv_cmd_valid[0] = 1'b0;
      tick();
      drv_rdata[0] = 32'h0000_0011;
      tick();
      tick();
      check_eq("rst_mid_busy_before", 64'(dut_busy[0]), 64'd1);
      #2;
      tb_rst = 1'b1;
      #1;
      check_idle_reset(0, "rst_mid_async");
      drv_rdata[0] = 32'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("rst_mid_no_resp", 64'(dut_resp_valid[0]), 64'd0);
      end
      tb_rst = 1'b0;
      tick();
      check_eq("rst_mid_no_resp_after", 64'(dut_resp_valid[0]), 64'd0);
      do_cmd(0, "after_rst", 32'h0000_0003, 1, 2, ST_OK, 32'd2, 2, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
